// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and transmit FSM encoding.
package uart_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA pushes into a byte FIFO, STATUS
// reports FSM/FIFO state, and a four-state FSM serialises bytes LSB first.
module uart_mmio_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] mem_rdata,
  output logic        txd
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  tx_state_e     r_state, w_state_nxt;
  logic [BW-1:0] r_baud_cnt, w_baud_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_txd, w_txd_nxt;
  logic          r_ovf;
  logic [31:0]   r_rdata;

  logic [1:0]    w_offset;
  logic          w_push, w_pop, w_rd, w_status_rd, w_drop, w_baud_end;
  logic          w_full, w_empty;
  logic [7:0]    w_fifo_head;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_offset    = mem_addr[3:2];
  assign w_push      = sel && mem_wmask[0] && (w_offset == OFF_DATA);
  assign w_rd        = sel && mem_rstrb;
  assign w_status_rd = w_rd && (w_offset == OFF_STATUS);
  assign w_drop      = w_push && w_full && !w_pop;
  assign w_baud_end  = (r_baud_cnt == BAUD_LAST);
  assign w_unused    = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8], mem_wmask[3:1]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (mem_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt + BW'(1);
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_baud_nxt = '0;
        w_txd_nxt  = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_head;
          w_state_nxt = ST_START;
          w_txd_nxt   = 1'b0;
        end
      end
      ST_START: begin
        if (w_baud_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = ST_DATA;
          w_txd_nxt   = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = r_bit_cnt + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_txd_nxt   = r_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit so frames abut.
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_head;
            w_state_nxt = ST_START;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  always_comb begin
    w_status                                = '0;
    w_status[STAT_BUSY]                     = (r_state != ST_IDLE);
    w_status[STAT_FULL]                     = w_full;
    w_status[STAT_EMPTY]                    = w_empty;
    w_status[STAT_OVF]                      = r_ovf;
    w_status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(w_count);
  end

  // A drop in the same cycle as a STATUS read keeps the flag set.
  always_ff @(posedge clk) begin
    if (!resetn)          r_ovf <= 1'b0;
    else if (w_drop)      r_ovf <= 1'b1;
    else if (w_status_rd) r_ovf <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn)   r_rdata <= '0;
    else if (w_rd) r_rdata <= (w_offset == OFF_STATUS) ? w_status : '0;
  end

  assign mem_rdata = r_rdata;
  assign txd       = r_txd;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Directed bench for uart_mmio_tx (DIV=16): bus writes push expected bytes to a
// scoreboard; a line monitor decodes txd frames and pops/compares them.
module tb_uart_mmio_tx;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        sel       = 1'b0;
  logic [31:0] mem_addr  = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] mem_rdata;
  logic        txd;

  uart_mmio_tx #(
    .CLK_FREQ_HZ (16),
    .BAUD        (1),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sel       (sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         errors    = 0;
  int         cyc       = 0;
  int         frames_rx = 0;
  logic [7:0] sb[$];
  int         starts[$];
  int         edges[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data, input logic [3:0] mask);
    sel       = 1'b1;
    mem_addr  = addr;
    mem_wdata = {24'hABCDEF, data};
    mem_wmask = mask;
    @(posedge clk);
    #1;
    sel       = 1'b0;
    mem_wmask = '0;
  endtask

  task automatic bus_read(input logic [31:0] addr);
    sel       = 1'b1;
    mem_rstrb = 1'b1;
    mem_addr  = addr;
    @(posedge clk);
    #1;
    sel       = 1'b0;
    mem_rstrb = 1'b0;
  endtask

  // Line monitor: samples mid-bit on the falling clock edge.
  initial begin
    logic       active;
    logic       prev;
    int         cnt;
    int         k;
    logic [7:0] byte_rx;
    logic [31:0] exp;
    active = 1'b0;
    prev   = 1'b1;
    cnt    = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (txd !== prev) edges.push_back(cyc);
      prev = txd;
      if (!resetn) begin
        active = 1'b0;
      end else if (!active) begin
        if (txd === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
          starts.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt % DIV == DIV / 2) begin
          k = cnt / DIV;
          if (k == 0) begin
            check("rx_start_bit", {31'b0, txd}, 32'h0);
          end else if (k <= 8) begin
            byte_rx[k-1] = txd;
          end else begin
            check("rx_stop_bit", {31'b0, txd}, 32'h1);
            frames_rx++;
            exp = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'hFFFF_FFFF;
            check("rx_byte", {24'b0, byte_rx}, exp);
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int n0;
    int fr0;

    // Reset state.
    resetn = 1'b0;
    idle(3);
    check("reset_txd", {31'b0, txd}, 32'h1);
    check("reset_rdata", mem_rdata, 32'h0);
    resetn = 1'b1;
    idle(2);

    // STATUS read when idle: registered, visible one cycle after the strobe.
    sel = 1'b1; mem_rstrb = 1'b1; mem_addr = 32'h4;
    #2;
    check("status_no_comb_path", mem_rdata, 32'h0);
    @(posedge clk);
    #1;
    sel = 1'b0; mem_rstrb = 1'b0;
    check("status_idle", mem_rdata, 32'h0000_0004);
    idle(1);
    check("rdata_hold", mem_rdata, 32'h0000_0004);

    // Writes that must not queue anything; reserved offsets read zero.
    bus_write(32'h8, 8'h77, 4'hF);
    bus_write(32'h0, 8'h66, 4'hE);
    bus_write(32'hC, 8'h99, 4'hF);
    idle(4);
    bus_read(32'h8);
    check("rd_off2_zero", mem_rdata, 32'h0);
    bus_read(32'h4);
    check("status_after_ignored_writes", mem_rdata, 32'h0000_0004);
    bus_read(32'hC);
    check("rd_off3_zero", mem_rdata, 32'h0);
    bus_read(32'h4);
    bus_read(32'h0);
    check("rd_data_reg_zero", mem_rdata, 32'h0);

    // Single 0x55 frame: alternating levels, 16 cycles each, 160 total.
    edges.delete();
    sb.push_back(8'h55);
    bus_write(32'h0, 8'h55, 4'hF);
    idle(159);
    bus_read(32'h4);
    check("s55_busy_last_cycle", mem_rdata, 32'h0000_0005);
    idle(1);
    bus_read(32'h4);
    check("s55_idle_after_frame", mem_rdata, 32'h0000_0004);
    check("s55_edge_count", edges.size(), 32'd10);
    for (int i = 1; i < edges.size() && i < 10; i++)
      check("s55_bit_period", edges[i] - edges[i-1], DIV);

    // Leader frame, then 0xA3 and 0x0F queued behind it: count 2 -> 1 -> 0.
    n0 = starts.size();
    sb.push_back(8'h3C); sb.push_back(8'hA3); sb.push_back(8'h0F);
    bus_write(32'h0, 8'h3C, 4'hF);
    bus_write(32'h0, 8'hA3, 4'hF);
    bus_write(32'h0, 8'h0F, 4'hF);
    bus_read(32'h4);
    check("b2b_count2", mem_rdata, 32'h0000_0021);
    idle(166);
    bus_read(32'h4);
    check("b2b_count1", mem_rdata, 32'h0000_0011);
    idle(159);
    bus_read(32'h4);
    check("b2b_count0_busy", mem_rdata, 32'h0000_0005);
    idle(159);
    bus_read(32'h4);
    check("b2b_idle", mem_rdata, 32'h0000_0004);
    check("b2b_frames", starts.size() - n0, 32'd3);
    for (int i = n0 + 1; i < starts.size() && i < n0 + 3; i++)
      check("b2b_no_gap", starts[i] - starts[i-1], FRAME);

    // Overflow: one byte popped, four queued, sixth write dropped.
    for (int i = 0; i < 5; i++) begin
      sb.push_back(8'hC0 + 8'(i));
      bus_write(32'h0, 8'hC0 + 8'(i), 4'hF);
    end
    bus_read(32'h4);
    check("ovf_full", mem_rdata, 32'h0000_0043);
    bus_write(32'h0, 8'hC5, 4'hF);
    idle(163);
    bus_read(32'h4);
    check("ovf_sticky", mem_rdata, 32'h0000_0039);
    bus_read(32'h4);
    check("ovf_cleared_by_read", mem_rdata, 32'h0000_0031);
    idle(640);
    bus_read(32'h4);
    check("ovf_drained_idle", mem_rdata, 32'h0000_0004);
    check("scoreboard_empty", sb.size(), 32'd0);

    // Reset mid-frame (data bit 4 of 0xFF) with two bytes queued.
    fr0 = frames_rx;
    bus_write(32'h0, 8'hFF, 4'hF);
    bus_write(32'h0, 8'h11, 4'hF);
    bus_write(32'h0, 8'h22, 4'hF);
    bus_read(32'h4);
    check("abort_two_queued", mem_rdata, 32'h0000_0021);
    idle(84);
    resetn = 1'b0;
    idle(1);
    check("abort_txd_high", {31'b0, txd}, 32'h1);
    check("abort_rdata_cleared", mem_rdata, 32'h0);
    resetn = 1'b1;
    idle(2);
    bus_read(32'h4);
    check("abort_status", mem_rdata, 32'h0000_0004);
    idle(400);
    check("abort_nothing_sent", frames_rx - fr0, 32'd0);
    check("abort_line_idle", {31'b0, txd}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_mmio_tx.md
UART_MMIO_TX -- requirements
Module: uart_mmio_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 12000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of TX byte entries (power of two, at least 2).
REQ-004 SHALL have port clk  input  1  system clock, all logic on posedge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sel  input  1  block selected by SOC address decode.
REQ-007 SHALL have port mem_addr  input  32  byte address; only bits [3:2] are decoded.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wmask  input  4  byte write enables; nonzero with sel means write.
REQ-010 SHALL have port mem_rstrb  input  1  read strobe.
REQ-011 SHALL have port mem_rdata  output  32  registered read data.
REQ-012 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-013 SHALL apply reset clk and resetn exactly as stated: resetn synchronous, active-low; clock clk.
REQ-014 SHALL compute DIV = CLK_FREQ_HZ / BAUD (integer division, DIV >= 2); every bit lasts exactly DIV cycles; frame = 10*DIV cycles.
REQ-015 SHALL decode the register map: offset 0 DATA (write-only), offset 1 STATUS (read), offsets 2 and 3 read 0 and ignore writes.
REQ-016 SHALL push mem_wdata[7:0] into the FIFO when sel, mem_wmask[0] and offset 0 are all asserted; writes with mem_wmask[0]=0 are ignored.
REQ-017 SHALL drop a push when the FIFO is full and set sticky STATUS.overflow, except when a pop occurs in the same cycle, in which case the push is accepted and count is unchanged.
REQ-018 SHALL register mem_rdata one cycle after sel&&mem_rstrb; mem_rdata holds its value otherwise.
REQ-019 SHALL return STATUS as: bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow, bits[7:4] FIFO count, other bits 0.
REQ-020 SHALL clear overflow on a STATUS read; an overflow event in the same cycle wins, and the returned value shows the pre-clear state.
REQ-021 SHALL run FSM states IDLE, START, DATA, STOP: IDLE->START pops the FIFO head into the shift register when non-empty; START->DATA after DIV; DATA->STOP after 8 bits; STOP->START (pop) if non-empty, else STOP->IDLE after DIV.
REQ-022 SHALL drive txd registered: 0 in START, shift[0] LSB-first in DATA, 1 in STOP and IDLE.
REQ-023 SHALL assert txd=0 on the cycle after the pop, with no idle gap between back-to-back frames.
REQ-024 SHALL use a 3-bit bit counter and a baud counter of width $clog2(DIV), counting 0..DIV-1 and reloading 0 at each bit boundary.
REQ-025 SHALL use FIFO pointers of width $clog2(FIFO_DEPTH) that wrap modulo depth, and a count of width $clog2(FIFO_DEPTH)+1.

Reset
REQ-026 SHALL on resetn=0 set state IDLE, txd 1, FIFO empty (pointers and count 0), overflow 0, mem_rdata 0, and counters 0.
REQ-027 SHALL abort an in-flight frame on reset: txd goes 1 on the next cycle, and queued bytes are discarded.

Structure
REQ-028 SHALL place the register offsets, STATUS bit positions and FSM state encoding in the shared package uart_pkg.
REQ-029 SHALL instantiate one sub-module, sync_fifo (parameters WIDTH=8, DEPTH), providing push, pop, full, empty and count.
REQ-030 SHALL contain no combinational path from the bus inputs to txd or mem_rdata.

Verification
REQ-031 SHALL use bench parameters CLK_FREQ_HZ=16, BAUD=1 (DIV=16) for all scenarios below.
REQ-032 SHALL cover: write 0x55 to offset 0 -> txd 0,1,0,1,0,1,0,1,0,1 with 16 cycles per bit, 160 cycles total, then busy=0.
REQ-033 SHALL cover: write 0xA3 then 0x0F back-to-back -> 20 contiguous bit periods with no gap; STATUS count goes 2->1->0.
REQ-034 SHALL cover: 6 writes during the first frame with depth 4 -> 5 bytes transmitted (1 popped plus 4 queued), 6th dropped, STATUS=0x?9 overflow set; the next STATUS read returns bit3=0.
REQ-035 SHALL cover: STATUS read with the FIFO idle and empty -> mem_rdata=0x00000004 exactly one cycle after mem_rstrb.
REQ-036 SHALL cover: resetn=0 during DATA bit 4 of 0xFF with 2 bytes queued -> txd=1 next cycle, STATUS=0x04 afterwards, nothing transmitted.
